nibble_serial_add_ctrl: RTL

//  Multi-cycle WIDTH-bit add/sub sequencer built on one shared 4-bit CLA slice (adder_4_bit).

---
 rtl/nibble_serial_add_ctrl_pkg.sv | 12 +
 rtl/nibble_serial_add_ctrl_if.sv | 29 ++
 rtl/nibble_serial_add_ctrl_adder_4_bit.sv | 32 +++
 rtl/nibble_serial_add_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared types and constants for the nibble-serial add/sub sequencer.
package nsa_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    NSA_IDLE,
    NSA_RUN,
    NSA_DONE
  } nsa_state_t;

endpackage

// File: rtl/nibble_serial_add_ctrl_if.sv
// Operand request / result handshake bundle for nibble_serial_add_ctrl.
interface nibble_serial_add_ctrl_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_sub;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_sum;
  logic             o_cout;
  logic             o_overflow;
  logic             o_zero;
  logic             o_busy;

  modport slave (
    input  i_valid, i_a, i_b, i_sub, i_ready,
    output o_ready, o_valid, o_sum, o_cout, o_overflow, o_zero, o_busy
  );

  modport master (
    output i_valid, i_a, i_b, i_sub, i_ready,
    input  o_ready, o_valid, o_sum, o_cout, o_overflow, o_zero, o_busy
  );

endinterface

// File: rtl/nibble_serial_add_ctrl_adder_4_bit.sv
// 4-bit carry-lookahead slice with group generate/propagate and signed overflow.
module adder_4_bit (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       g_o,
  output logic       p_o,
  output logic       ovf_o
);

  logic [3:0] g_c;
  logic [3:0] p_c;
  logic [4:0] c_c;

  always_comb begin
    g_c    = a_i & b_i;
    p_c    = a_i ^ b_i;
    c_c[0] = cin_i;
    c_c[1] = g_c[0] | (p_c[0] & cin_i);
    c_c[2] = g_c[1] | (p_c[1] & g_c[0]) | (p_c[1] & p_c[0] & cin_i);
    c_c[3] = g_c[2] | (p_c[2] & g_c[1]) | (p_c[2] & p_c[1] & g_c[0])
           | (p_c[2] & p_c[1] & p_c[0] & cin_i);
    g_o    = g_c[3] | (p_c[3] & g_c[2]) | (p_c[3] & p_c[2] & g_c[1])
           | (p_c[3] & p_c[2] & p_c[1] & g_c[0]);
    p_o    = &p_c;
    c_c[4] = g_o | (p_o & cin_i);
    sum_o  = p_c ^ c_c[3:0];
    ovf_o  = c_c[4] ^ c_c[3];
  end

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Multi-cycle add/sub sequencer feeding one 4-bit CLA slice a nibble per cycle, LSB first.
// Optional early termination on all-zero upper operand nibbles: define NSA_EARLY_TERM_EN.
module nibble_serial_add_ctrl
  import nsa_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  nibble_serial_add_ctrl_if.slave   bus
);

  localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
  localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  if (WIDTH % NIBBLE_W != 0 || WIDTH == 0) begin : g_width_chk
    $error("nibble_serial_add_ctrl: WIDTH must be a non-zero multiple of 4");
  end

  typedef logic [NIBBLES-1:0][NIBBLE_W-1:0] nib_vec_t;

  nsa_state_t           state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 carry_q, carry_d;
  nib_vec_t             a_q, a_d;
  nib_vec_t             b_q, b_d;
  nib_vec_t             sum_q, sum_d;
  logic                 cout_q, cout_d;
  logic                 ovf_q, ovf_d;
  logic                 zero_q, zero_d;
  logic                 valid_q, valid_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;

  logic                 accept_c;
  logic [NIBBLE_W-1:0]  slice_sum_c;
  logic                 slice_g_c;
  logic                 slice_p_c;
  logic                 slice_ovf_c;
  logic                 slice_cout_c;
  logic                 last_c;
  logic                 early_c;

  adder_4_bit u_slice (
    .a_i   (a_q[idx_q]),
    .b_i   (b_q[idx_q]),
    .cin_i (carry_q),
    .sum_o (slice_sum_c),
    .g_o   (slice_g_c),
    .p_o   (slice_p_c),
    .ovf_o (slice_ovf_c)
  );

  assign accept_c     = (state_q == NSA_IDLE) && bus.i_valid;
  assign slice_cout_c = slice_g_c | (slice_p_c & carry_q);
  assign last_c       = (idx_q == IDX_W'(NIBBLES - 1));

`ifdef NSA_EARLY_TERM_EN
  logic               sub_q;
  logic [NIBBLES-1:0] nz_c;
  logic [NIBBLES-1:0] at_or_above_c;

  for (genvar g = 0; g < NIBBLES; g++) begin : g_nz
    assign nz_c[g] = |{a_q[g], b_q[g]};
  end

  // Finish once this nibble leaves no carry and every nibble above it is zero in both operands.
  assign at_or_above_c = {NIBBLES{1'b1}} << idx_q;
  assign early_c       = !sub_q && !slice_cout_c && !(|(nz_c & (at_or_above_c << 1)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sub_q <= 1'b0;
    end else if (accept_c) begin
      sub_q <= bus.i_sub;
    end
  end
`else
  assign early_c = 1'b0;
`endif

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;

    case (state_q)
      NSA_IDLE: begin
        if (accept_c) begin
          a_d     = bus.i_a;
          b_d     = bus.i_b ^ {WIDTH{bus.i_sub}};
          carry_d = bus.i_sub;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          zero_d  = 1'b0;
          state_d = NSA_RUN;
        end
      end
      NSA_RUN: begin
        sum_d[idx_q] = slice_sum_c;
        carry_d      = slice_cout_c;
        idx_d        = idx_q + IDX_W'(1);
        if (last_c) begin
          cout_d  = slice_cout_c;
          ovf_d   = slice_ovf_c;
          zero_d  = (sum_d == '0);
          state_d = NSA_DONE;
        end else if (early_c) begin
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          zero_d  = (sum_d == '0);
          state_d = NSA_DONE;
        end
      end
      NSA_DONE: begin
        if (bus.i_ready) begin
          state_d = NSA_IDLE;
        end
      end
      default: state_d = NSA_IDLE;
    endcase

    valid_d = (state_d == NSA_DONE);
    ready_d = (state_d == NSA_IDLE);
    busy_d  = (state_d != NSA_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= NSA_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.o_sum      = sum_q;
  assign bus.o_cout     = cout_q;
  assign bus.o_overflow = ovf_q;
  assign bus.o_zero     = zero_q;
  assign bus.o_valid    = valid_q;
  assign bus.o_ready    = ready_q;
  assign bus.o_busy     = busy_q;

endmodule
